// File: rtl/mcp3008_scan.sv
// Free-running MCP3008 scanner: converts channels 0..NUM_CH-1 round-robin (single-ended)
// over SPI mode 0 and reports each 10-bit result as a one-cycle strobe.
module mcp3008_scan #(
    parameter int CLK_DIV = 63,
    parameter int NUM_CH  = 8,
    parameter int CS_HIGH = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_mosi,
    input  logic       adc_miso,
    output logic       sample_valid,
    output logic [2:0] sample_ch,
    output logic [9:0] sample_data,
    output logic       scan_done
);
    localparam int MAX_CNT = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CSH_LAST  = CNT_W'(CS_HIGH - 1);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);
    localparam logic [4:0]       LAST_RISE = 5'd17;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rise_q, rise_d;
    logic [2:0]       ch_q, ch_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [9:0]       shift_q, shift_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [2:0]       sample_ch_q, sample_ch_d;
    logic [9:0]       sample_data_q, sample_data_d;
    logic             start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rise_q        <= '0;
            ch_q          <= '0;
            cmd_q         <= '0;
            shift_q       <= '0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            sample_ch_q   <= '0;
            sample_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rise_q        <= rise_d;
            ch_q          <= ch_d;
            cmd_q         <= cmd_d;
            shift_q       <= shift_d;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        rise_d        = rise_q;
        ch_d          = ch_q;
        cmd_d         = cmd_q;
        shift_d       = shift_q;
        cs_n_d        = cs_n_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        valid_d       = 1'b0;
        done_d        = 1'b0;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;
        start         = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                start = enable;
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rise_d  = 5'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next command bit; zeros fill in after D0.
                        sclk_d = 1'b0;
                        mosi_d = cmd_q[3];
                        cmd_d  = {cmd_q[2:0], 1'b0};
                    end else if (rise_q == LAST_RISE) begin
                        state_d       = HOLD;
                        cs_n_d        = 1'b1;
                        valid_d       = 1'b1;
                        done_d        = (ch_q == CH_LAST);
                        sample_ch_d   = ch_q;
                        sample_data_d = shift_q;
                        ch_d          = (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
                    end else begin
                        sclk_d = 1'b1;
                        rise_d = rise_q + 5'd1;
                        // Rises 8..17 carry B9..B0; earlier rises (incl. the null bit) are skipped.
                        if (rise_q >= 5'd7) begin
                            shift_d = {shift_q[8:0], adc_miso};
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CSH_LAST) begin
                    start = enable;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SETUP;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            mosi_d  = 1'b1;
            cmd_d   = {1'b1, ch_q};
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_mosi     = mosi_q;
    assign sample_valid = valid_q;
    assign scan_done    = done_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;

endmodule

// File: tb/tb_mcp3008_scan.sv
// Bench for mcp3008_scan: an 8-channel and a 3-channel instance, each wired to a
// behavioural MCP3008 that decodes the command bits and returns a programmed word.
module tb_mcp3008_scan;
    localparam int CD0    = 4;
    localparam int NC0    = 8;
    localparam int CSH0   = 4;
    localparam int CD1    = 2;
    localparam int NC1    = 3;
    localparam int CSH1   = 1;
    localparam int FRAME0 = 35 * CD0 + CSH0;
    localparam int FRAME1 = 35 * CD1 + CSH1;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] data;
        logic       done;
        logic       cs_n;
        logic [4:0] cmd;
        int         rises;
        longint     cyc;
    } strobe_t;

    typedef struct {
        logic [9:0] adc_in;
        logic [2:0] ch;
        logic [9:0] data;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en [2];
    logic [9:0] adc_val [2][8];
    logic       idle_watch = 1'b0;
    longint     cyc = 0;
    int         n_pass = 0;
    int         n_tot = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CD  = (g == 0) ? CD0 : CD1;
        localparam int NC  = (g == 0) ? NC0 : NC1;
        localparam int CSH = (g == 0) ? CSH0 : CSH1;
        logic       cs_n, sclk, mosi, valid, done;
        logic       miso = 1'b0;
        logic [2:0] s_ch;
        logic [9:0] s_data;
        int         frames = 0, seen = 0, rises = 0, mosi_bad = 0, idle_bad = 0, stray_done = 0;
        logic [4:0] cmd = '0;
        logic [9:0] word = '0;
        strobe_t    q[$];

        mcp3008_scan #(.CLK_DIV(CD), .NUM_CH(NC), .CS_HIGH(CSH)) dut (
            .clk(clk), .rst(rst), .enable(en[g]),
            .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_mosi(mosi), .adc_miso(miso),
            .sample_valid(valid), .sample_ch(s_ch), .sample_data(s_data), .scan_done(done)
        );

        always @(negedge cs_n) frames++;

        always @(posedge sclk) begin
            if (seen != frames) begin
                seen  = frames;
                rises = 0;
            end
            rises++;
            if (rises <= 5) cmd = {cmd[3:0], mosi};
            else if (mosi) mosi_bad++;
            if (rises == 5) word = adc_val[g][cmd[2:0]];
        end

        // After fall k the ADC presents the bit sampled on rise k+1 (B9 on rise 8).
        always @(negedge sclk)
            miso = (rises >= 7 && rises <= 16) ? word[4'(16 - rises)] : 1'b0;

        always @(negedge clk) begin
            if (valid) q.push_back('{s_ch, s_data, done, cs_n, cmd, rises, cyc});
            if (done && !valid) stray_done++;
            if (idle_watch && (!cs_n || sclk || mosi || valid || done)) idle_bad++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_q0(input int n, input int budget);
        for (int i = 0; i < budget && u[0].q.size() < n; i++) tick(1);
        chk("strobe_wait0", (u[0].q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_rise0(input int n, input int budget);
        for (int i = 0; i < budget && u[0].rises != n; i++) tick(1);
        chk("rise_wait0", (u[0].rises == n) ? 1 : 0, 1);
    endtask

    initial begin
        int      base, exp_ch, nfr;
        longint  c0;
        strobe_t s;
        vec_t    tbl[9];

        for (int i = 0; i < 9; i++) begin
            tbl[i].ch     = 3'(i % NC0);
            tbl[i].adc_in = 10'((i % NC0) * 100 + 1);
            tbl[i].data   = 10'((i % NC0) * 100 + 1);
            tbl[i].done   = ((i % NC0) == NC0 - 1);
        end
        en[0] = 1'b0;
        en[1] = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int c = 0; c < 8; c++) adc_val[g][c] = '0;

        // Reset held with enable low: pins idle, no strobes.
        #2 rst = 1'b1;
        idle_watch = 1'b1;
        tick(1000);
        chk("rst_idle0", u[0].idle_bad, 0);
        chk("rst_idle1", u[1].idle_bad, 0);
        chk("rst_ch", u[0].s_ch, 0);
        chk("rst_data", u[0].s_data, 0);
        rst = 1'b0;
        tick(20);
        chk("idle_after_rst", u[0].idle_bad + u[1].idle_bad, 0);
        chk("idle_no_strobe", u[0].q.size() + u[1].q.size(), 0);
        idle_watch = 1'b0;

        // Single frame on channel 0.
        adc_val[0][0] = 10'h2A5;
        c0 = cyc;
        en[0] = 1'b1;
        wait_q0(1, 400);
        en[0] = 1'b0;
        s = u[0].q[0];
        chk("single_latency", s.cyc - c0, 35 * CD0 + 1);
        chk("single_ch", s.ch, 0);
        chk("single_data", s.data, 10'h2A5);
        chk("single_done", s.done, 0);
        chk("single_cs_high", s.cs_n, 1);
        chk("single_cmd", s.cmd, 5'b11000);
        chk("single_rises", s.rises, 17);
        tick(20);
        chk("hold_ch", u[0].s_ch, 0);
        chk("hold_data", u[0].s_data, 10'h2A5);
        chk("single_only_one", u[0].q.size(), 1);
        chk("single_cs_idle", u[0].cs_n, 1);

        // Full scan from reset, table-driven.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        base = u[0].q.size();
        for (int i = 0; i < NC0; i++) adc_val[0][tbl[i].ch] = tbl[i].adc_in;
        en[0] = 1'b1;
        wait_q0(base + 9, 9 * FRAME0 + 200);
        en[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s = u[0].q[base + i];
            chk("scan_ch", s.ch, tbl[i].ch);
            chk("scan_data", s.data, tbl[i].data);
            chk("scan_done", s.done, tbl[i].done);
            chk("scan_cmd", s.cmd, {2'b11, tbl[i].ch});
            if (i > 0) chk("scan_gap", s.cyc - u[0].q[base + i - 1].cyc, FRAME0);
        end
        tick(20);

        // Disable at rise 9 of the ch 3 frame, then re-enable.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        base = u[0].q.size();
        en[0] = 1'b1;
        wait_q0(base + 3, 3 * FRAME0 + 200);
        wait_rise0(9, 2 * FRAME0);
        en[0] = 1'b0;
        wait_q0(base + 4, FRAME0 + 50);
        chk("dis_ch", u[0].q[base + 3].ch, 3);
        chk("dis_data", u[0].q[base + 3].data, 301);
        nfr = u[0].frames;
        tick(300);
        chk("dis_no_frame", u[0].frames, nfr);
        chk("dis_no_strobe", u[0].q.size(), base + 4);
        chk("dis_cs_high", u[0].cs_n, 1);
        c0 = cyc;
        en[0] = 1'b1;
        wait_q0(base + 5, FRAME0 + 50);
        chk("reen_ch", u[0].q[base + 4].ch, 4);
        chk("reen_cmd", u[0].q[base + 4].cmd, 5'b11100);
        chk("reen_latency", u[0].q[base + 4].cyc - c0, 35 * CD0 + 1);

        // Asynchronous reset at rise 12 of the ch 5 frame.
        wait_rise0(12, 2 * FRAME0);
        rst = 1'b1;
        base = u[0].q.size();
        #1;
        chk("arst_cs", u[0].cs_n, 1);
        chk("arst_sclk", u[0].sclk, 0);
        chk("arst_mosi", u[0].mosi, 0);
        chk("arst_valid", u[0].valid, 0);
        tick(5);
        chk("arst_no_strobe", u[0].q.size(), base);
        chk("arst_ch", u[0].s_ch, 0);
        chk("arst_data", u[0].s_data, 0);
        rst = 1'b0;
        c0 = cyc;
        wait_q0(base + 1, FRAME0 + 50);
        chk("arst_first_ch", u[0].q[base].ch, 0);
        chk("arst_first_data", u[0].q[base].data, 1);
        chk("arst_latency", u[0].q[base].cyc - c0, 35 * CD0 + 1);
        en[0] = 1'b0;
        tick(20);

        // Random words and random run lengths against a channel-pointer model.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_ch = 0;
        base = u[0].q.size();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) adc_val[0][c] = 10'($urandom_range(0, 1023));
            nfr = int'($urandom_range(1, 10));
            en[0] = 1'b1;
            wait_q0(base + nfr, nfr * FRAME0 + 200);
            en[0] = 1'b0;
            for (int j = 0; j < nfr; j++) begin
                s = u[0].q[base + j];
                chk("rand_ch", s.ch, exp_ch);
                chk("rand_data", s.data, adc_val[0][exp_ch]);
                chk("rand_done", s.done, (exp_ch == NC0 - 1) ? 1 : 0);
                exp_ch = (exp_ch + 1) % NC0;
            end
            base += nfr;
            tick(int'($urandom_range(0, 40)));
        end
        tick(20);

        // Three-channel instance with minimum divider and CS gap.
        for (int c = 0; c < NC1; c++) adc_val[1][c] = 10'($urandom_range(0, 1023));
        en[1] = 1'b1;
        for (int i = 0; i < 4 * FRAME1 + 200 && u[1].q.size() < 4; i++) tick(1);
        chk("nc3_wait", (u[1].q.size() >= 4) ? 1 : 0, 1);
        en[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp_ch = j % NC1;
            s = u[1].q[j];
            chk("nc3_ch", s.ch, exp_ch);
            chk("nc3_done", s.done, (exp_ch == NC1 - 1) ? 1 : 0);
            chk("nc3_data", s.data, adc_val[1][exp_ch]);
            if (j > 0) chk("nc3_gap", s.cyc - u[1].q[j - 1].cyc, FRAME1);
        end
        chk("nc3_cmd_ch2", u[1].q[2].cmd, 5'b11010);
        chk("nc3_rises", u[1].q[0].rises, 17);
        tick(300);
        chk("nc3_cs_idle", u[1].cs_n, 1);

        chk("mosi_tail0", u[0].mosi_bad, 0);
        chk("mosi_tail1", u[1].mosi_bad, 0);
        chk("stray_done0", u[0].stray_done, 0);
        chk("stray_done1", u[1].stray_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
